// File: rtl/asteroid_pkg.sv
// Shared encodings and defaults for the asteroid slot scheduler.
package asteroid_pkg;

  localparam int unsigned TICK_LINE_DEFAULT = 480;
  localparam int unsigned SPEED_W           = 3;

  typedef enum logic [1:0] {
    SLOT_FREE     = 2'd0,
    SLOT_LIVE     = 2'd1,
    SLOT_COOLDOWN = 2'd2
  } slot_state_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/asteroid_slot.sv
// One asteroid slot: occupancy state, move-rate divider and respawn cooldown.
module asteroid_slot
  import asteroid_pkg::*;
#(
  parameter int unsigned COOLDOWN = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pixpulse,
  input  logic               scan_sel_i,
  input  logic               hit_i,
  input  logic               grant_i,
  input  logic [SPEED_W-1:0] speed_i,
  output logic               move_o,
  output logic               live_o,
  output logic               free_c_o,
  output logic               free_nxt_c_o
);

  localparam int unsigned CD_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

  slot_state_e        state_q, state_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [SPEED_W-1:0] div_q, div_d;
  logic [CD_W-1:0]    cd_q, cd_d;
  logic               move_q, move_d;
  logic               live_q;

  // A hit on a live slot beats any move strobe due on the same pixel.
  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    div_d   = div_q;
    cd_d    = cd_q;
    move_d  = 1'b0;
    case (state_q)
      SLOT_FREE: begin
        if (grant_i) begin
          state_d = SLOT_LIVE;
          speed_d = speed_i;
          div_d   = speed_i;
        end
      end
      SLOT_LIVE: begin
        if (hit_i) begin
          state_d = SLOT_COOLDOWN;
          cd_d    = CD_W'(COOLDOWN - 1);
        end else if (scan_sel_i) begin
          if (div_q == '0) begin
            move_d = 1'b1;
            div_d  = speed_q;
          end else begin
            div_d = div_q - SPEED_W'(1);
          end
        end
      end
      SLOT_COOLDOWN: begin
        if (scan_sel_i) begin
          if (cd_q == '0) state_d = SLOT_FREE;
          else            cd_d    = cd_q - CD_W'(1);
        end
      end
      default: state_d = SLOT_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SLOT_FREE;
      speed_q <= '0;
      div_q   <= '0;
      cd_q    <= '0;
      move_q  <= 1'b0;
      live_q  <= 1'b0;
    end else if (pixpulse) begin
      state_q <= state_d;
      speed_q <= speed_d;
      div_q   <= div_d;
      cd_q    <= cd_d;
      move_q  <= move_d;
      live_q  <= (state_d == SLOT_LIVE);
    end
  end

  assign move_o       = move_q;
  assign live_o       = live_q;
  assign free_c_o     = (state_q == SLOT_FREE);
  assign free_nxt_c_o = (state_d == SLOT_FREE);

endmodule

// File: rtl/asteroid_sched.sv
// Frame-tick scan scheduler and spawn arbiter driving N_AST asteroid slots.
module asteroid_sched
  import asteroid_pkg::*;
#(
  parameter int unsigned N_AST     = 4,
  parameter int unsigned TICK_LINE = TICK_LINE_DEFAULT,
  parameter int unsigned COOLDOWN  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pixpulse,
  input  logic [9:0]               hcount,
  input  logic [9:0]               vcount,
  input  logic                     spawn_req,
  input  logic [2:0]               spawn_speed,
  input  logic [N_AST-1:0]         hit,
  output logic [N_AST-1:0]         move,
  output logic [N_AST-1:0]         live,
  output logic                     spawn_ack,
  output logic [$clog2(N_AST)-1:0] spawn_slot,
  output logic                     spawn_full,
  output logic [7:0]               frame_cnt
);

  localparam int unsigned      IDX_W    = $clog2(N_AST);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_AST - 1);

  scan_state_e      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             tick_c;
  logic [N_AST-1:0] scan_sel_c;
  logic [N_AST-1:0] grant_c;
  logic [N_AST-1:0] free_c;
  logic [N_AST-1:0] free_nxt_c;
  logic             any_free_c;
  logic [IDX_W-1:0] grant_idx_c;
  logic             ack_q;
  logic [IDX_W-1:0] slot_q;
  logic             full_q;
  logic [7:0]       frame_q;

  assign tick_c = pixpulse && (hcount == 10'd0) && (vcount == 10'(TICK_LINE));

  // Scan walks one slot per pixel after a tick; ticks outside IDLE are dropped.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (pixpulse) begin
      case (state_q)
        ST_IDLE: begin
          if (tick_c) begin
            state_d = ST_SCAN;
            idx_d   = '0;
          end
        end
        ST_SCAN: begin
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    scan_sel_c = '0;
    if (state_q == ST_SCAN) scan_sel_c[idx_q] = 1'b1;
  end

  // Lowest-index free slot; uses registered state so same-pixel frees wait a pixel.
  always_comb begin
    any_free_c  = 1'b0;
    grant_idx_c = '0;
    for (int i = N_AST - 1; i >= 0; i--) begin
      if (free_c[i]) begin
        any_free_c  = 1'b1;
        grant_idx_c = IDX_W'(i);
      end
    end
    grant_c = '0;
    if (spawn_req && any_free_c) grant_c[grant_idx_c] = 1'b1;
  end

  for (genvar g = 0; g < N_AST; g++) begin : g_slot
    asteroid_slot #(
      .COOLDOWN(COOLDOWN)
    ) u_slot (
      .clk          (clk),
      .rst          (rst),
      .pixpulse     (pixpulse),
      .scan_sel_i   (scan_sel_c[g]),
      .hit_i        (hit[g]),
      .grant_i      (grant_c[g]),
      .speed_i      (spawn_speed),
      .move_o       (move[g]),
      .live_o       (live[g]),
      .free_c_o     (free_c[g]),
      .free_nxt_c_o (free_nxt_c[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      ack_q   <= 1'b0;
      slot_q  <= '0;
      full_q  <= 1'b0;
      frame_q <= '0;
    end else if (pixpulse) begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ack_q   <= spawn_req && any_free_c;
      slot_q  <= (spawn_req && any_free_c) ? grant_idx_c : '0;
      full_q  <= ~|free_nxt_c;
      if (tick_c) frame_q <= frame_q + 8'd1;
    end
  end

  assign spawn_ack  = ack_q;
  assign spawn_slot = slot_q;
  assign spawn_full = full_q;
  assign frame_cnt  = frame_q;

endmodule

// File: doc/asteroid_sched.md
ASTEROID_SCHED -- requirements
Module: asteroid_sched

Interface
REQ-001 The block SHALL have parameter N_AST, default 4: number of asteroid slots controlled.
REQ-002 The block SHALL have parameter TICK_LINE, default 480: vcount value that marks the frame tick (first blank line).
REQ-003 The block SHALL have parameter COOLDOWN, default 2: frames a destroyed slot stays unavailable before respawn.
REQ-004 The block SHALL have port clk, input, 1: 100 MHz system clock, the only clock.
REQ-005 The block SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 The block SHALL have port pixpulse, input, 1: 25 MHz pixel enable, one clk in four.
REQ-007 The block SHALL have ports hcount and vcount, input, 10 each: current raster position.
REQ-008 The block SHALL have port spawn_req, input, 1: level request to place a new asteroid.
REQ-009 The block SHALL have port spawn_speed, input, 3: frames between moves minus one (0 = every frame).
REQ-010 The block SHALL have port hit, input, N_AST: per-slot destroyed indication.
REQ-011 The block SHALL have port move, output, N_AST: per-slot move strobe to asteroid instances.
REQ-012 The block SHALL have port live, output, N_AST: slot currently occupied (drives asteroid draw enable).
REQ-013 The block SHALL have ports spawn_ack (1), spawn_slot ($clog2(N_AST)) and spawn_full (1), all outputs: spawn handshake.
REQ-014 The block SHALL have port frame_cnt, output, 8: frame counter, wraps 255->0.

Function
REQ-015 All state and outputs SHALL change only on clk edges where pixpulse=1; outputs are registered and hold for one full pixpulse period.
REQ-016 Frame tick SHALL be pixpulse & hcount==0 & vcount==TICK_LINE; frame_cnt increments on each tick.
REQ-017 The scan FSM SHALL have states IDLE, SCAN, DONE: IDLE->SCAN on tick with idx=0; SCAN advances idx by one per pixpulse; SCAN->DONE after idx=N_AST-1; DONE->IDLE next pixpulse.
REQ-018 A tick arriving outside IDLE SHALL be ignored.
REQ-019 Each slot SHALL hold state FREE, LIVE or COOLDOWN, a 3-bit divider and a cooldown counter.
REQ-020 In SCAN, a LIVE slot idx SHALL: if divider==0, assert move[idx] for that pixpulse period and reload divider with its stored speed; else decrement divider.
REQ-021 In SCAN, a COOLDOWN slot SHALL decrement its counter; at counter==0 it SHALL become FREE instead.
REQ-022 move SHALL be one-hot or zero; at most one bit high per pixpulse period.
REQ-023 hit[i] while slot i LIVE SHALL move it to COOLDOWN with counter=COOLDOWN-1, clear live[i] next pixpulse; hit on non-LIVE slot ignored.
REQ-024 hit[i] on the pixpulse that would strobe move[i] SHALL win: no move, slot to COOLDOWN.
REQ-025 spawn_req with any FREE slot SHALL grant the lowest-index FREE slot: spawn_ack=1 and spawn_slot=index for one pixpulse period, slot LIVE, speed and divider loaded from spawn_speed.
REQ-026 Slots freed in the current pixpulse (COOLDOWN->FREE) SHALL not be granted until the next pixpulse.
REQ-027 spawn_req held high SHALL produce at most one grant per pixpulse period; spawn_ack deasserts whenever spawn_req is low.
REQ-028 spawn_full SHALL be 1 when no slot is FREE; spawn_req then gets no ack and is not queued.

Reset
REQ-029 rst SHALL, on any clk edge regardless of pixpulse, force: FSM IDLE, idx 0, all slots FREE, dividers and cooldowns 0, move 0, live 0, spawn_ack 0, spawn_slot 0, spawn_full 0, frame_cnt 0.
REQ-030 rst mid-SCAN SHALL abort the scan; no move strobe is emitted on the reset edge or the following pixpulse.

Structure
REQ-031 Slot state encoding, FSM state encoding and the frame-tick line constant SHALL live in a shared package, asteroid_pkg.
REQ-032 Per-slot state/divider/cooldown logic SHALL be one sub-module, asteroid_slot, instanced N_AST times; arbitration and FSM stay in asteroid_sched.

Verification
REQ-033 Reset then spawn_req=1, spawn_speed=0 for one pixpulse -> spawn_ack=1, spawn_slot=0, live=0001; next tick -> move[0] pulses on scan idx 0 every frame.
REQ-034 Four spawns, speeds 0,1,2,3 -> live=1111, spawn_full=1; over 12 frames move[0..3] count 12,6,4,3; fifth spawn_req gets no ack.
REQ-035 hit[2] coincident with move[2] strobe -> move[2] stays 0, live[2] clears; slot 2 FREE after exactly 2 ticks; next spawn_req granted slot 2.
REQ-036 Slots 0 and 1 LIVE, spawn_req held 3 pixpulses -> grants slot 2 then slot 3, third cycle no ack, spawn_full=1.
REQ-037 rst asserted at scan idx 1 with all slots LIVE -> no further move, all outputs zero; frame_cnt 0.
REQ-038 Run 256 ticks -> frame_cnt wraps to 0; tick line while in SCAN never double-scans.
